instr_cache: RTL
================

Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the IF-stage program counter and a slow backing instruction memory.
- Returns the 32-bit instruction word on a hit in the same cycle.
- On a miss, asserts a stall to the hazard unit and refills one whole line through a req/ack word interface.
- Replaces the flat single-cycle instruction ROM in the fetch path.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_i  in  1  fetch request valid.
- addr_i  in  ADDR_W  byte address from the PC; bits [1:0] are ignored.
- inv_i  in  1  invalidate all lines (one-cycle pulse).
- data_o  out  32  instruction word; valid when hit_o=1.
- hit_o  out  1  lookup hit (combinational).
- stall_o  out  1  fetch must hold the PC and the IF/ID register.
- mem_req_o  out  1  backing-memory word request.
- mem_addr_o  out  ADDR_W  word-aligned backing-memory address.
- mem_ack_i  in  1  backing-memory word returned this cycle.
- mem_data_i  in  32  returned word.

Behaviour:
- Address split:
  - offset = addr[log2(WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage:
  - valid[LINES] is reset to 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, REFILL, FINISH.
- IDLE:
  - hit_o = req_i & valid[index] & (tag match) & ~inv_i.
  - data_o = data[index][offset] when hit_o=1, else 0.
  - On a miss with req_i=1: stall_o=1 in the same cycle. Capture line base = {tag, index, 0s} and the index. Clear the word counter. Go to REFILL.
  - With req_i=0: stall_o=0.
- REFILL:
  - mem_req_o=1 and mem_addr_o = base + 4*count, held stable until mem_ack_i.
  - Each cycle with mem_ack_i=1: write mem_data_i to data[idx][count] and increment count.
  - On the ack for count=WORDS-1: go to FINISH.
  - mem_ack_i is ignored when mem_req_o=0.
  - The cycle after an ack, mem_req_o stays 1 for the next word; back-to-back acks are legal, one word per cycle maximum.
  - stall_o=1 and hit_o=0 throughout; addr_i changes are ignored.
- FINISH:
  - Write the tag. Set valid[idx]=1 unless an invalidate occurred during this refill (sticky flag).
  - stall_o=1, mem_req_o=0. Go to IDLE.
  - The re-presented address hits the cycle after FINISH.
- Miss latency with an ack every cycle: WORDS+2 stall cycles.
- inv_i:
  - Clears all valid bits at the edge, in any state.
  - In IDLE, a simultaneous req_i is treated as a miss (hit_o forced 0).
  - During REFILL, the refill completes but the line is left invalid.
- Reset:
  - rst=0 at an edge forces IDLE, clears valid and count.
  - Outputs after reset: hit_o=0, stall_o=0 (unless req_i causes a miss), mem_req_o=0, mem_addr_o=0, data_o=0.
  - Reset mid-refill abandons the line; no valid bit is set.
- Counter width: log2(WORDS)+1 bits. Wrap is impossible because the FSM leaves REFILL at WORDS-1.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
  - hit_cnt_o increments on every cycle with hit_o=1.
  - miss_cnt_o increments once per IDLE to REFILL transition.
  - Both saturate at 32'hFFFFFFFF and are not cleared by inv_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE=2'd0, REFILL=2'd1, FINISH=2'd2)
  - address-field width functions (clog2-based)
  - INSTR_W=32
- Sub-module icache_store holds the tag/data/valid arrays:
  - combinational read port
  - word write, tag write and valid set/clear-all ports
- The top-level module keeps the FSM, counter and handshake.

Test Plan:
- Reset then req_i=1, addr_i=32'h40 -> hit_o=0, stall_o=1; mem_addr_o sequence 0x40, 0x44, 0x48, 0x4C with ack every cycle; stall for 6 cycles; then hit_o=1 with data_o equal to the word for 0x40.
- After the line at 0x40 is filled, addr_i=0x4C -> hit_o=1 the same cycle, data_o equals the 0x4C word, mem_req_o=0.
- Conflict: fill 0x40, then fetch 0x140 (same index, different tag) -> miss and refill; the subsequent fetch of 0x40 misses again.
- Slow memory: mem_ack_i delayed 3 cycles per word -> mem_addr_o stable while waiting; stall lasts 4*4+2 cycles.
- inv_i pulsed during a refill of 0x80 -> refill completes, the next fetch of 0x80 misses; inv_i with req_i in IDLE on a filled line -> hit_o=0.
- rst=0 asserted on the second word of a refill -> next cycle mem_req_o=0, all valid bits are 0, and a fetch of the same address misses.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Holds the refill FSM encoding and the byte-address field widths.
// No ports; imported by instr_cache and icache_store.
package instr_cache_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Width of the word-offset field inside a line.
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Width of the line-index field.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: everything above byte bits, word offset and index.
  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - 2 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_store.sv
// Tag/data/valid storage for instr_cache: one combinational read port.
// Latency: reads are combinational; word, tag and valid writes land at the next edge.
// Backpressure: none, every write request is accepted in the cycle it is presented.
// Ports: rd_idx_i/rd_off_i -> rd_tag_o/rd_data_o/rd_valid_o (lookup);
//        word_we_i/wr_idx_i/wr_off_i/wr_data_i (refill word), tag_we_i/tag_i (line tag),
//        valid_set_i (mark wr_idx_i valid), inv_all_i (clear every valid bit).
module icache_store
  import instr_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 26,
  parameter int IDX_W = idx_w(LINES),
  parameter int OFF_W = off_w(WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   rd_idx_i,
  input  logic [OFF_W-1:0]   rd_off_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [INSTR_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  input  logic               word_we_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [OFF_W-1:0]   wr_off_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  input  logic               tag_we_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               valid_set_i,
  input  logic               inv_all_i
);

  // Tag and data are plain RAM arrays with no reset; only valid bits need one.
  logic [INSTR_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]   valid_q, valid_d;

  assign rd_data_o  = data_mem[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (word_we_i) data_mem[wr_idx_i][wr_off_i] <= wr_data_i;
    if (tag_we_i)  tag_mem[wr_idx_i]            <= tag_i;
  end

  // Invalidate-all wins over a simultaneous set of the refilled line.
  always_comb begin
    valid_d = valid_q;
    if (valid_set_i) valid_d[wr_idx_i] = 1'b1;
    if (inv_all_i)   valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between the fetch PC and slow instruction memory.
// Latency: hit returns data the same cycle; a miss stalls WORDS+2 cycles with an ack every cycle.
// Backpressure: stall_o holds fetch during refill; memory paces the refill via mem_req_o/mem_ack_i.
// Ports: clk, rst (sync active-low); req_i/addr_i/inv_i lookup; data_o/hit_o/stall_o result;
//        mem_req_o/mem_addr_o/mem_ack_i/mem_data_i word refill interface.
// Build option ICACHE_PERF_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic               inv_i,
  output logic [INSTR_W-1:0] data_o,
  output logic               hit_o,
  output logic               stall_o,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [INSTR_W-1:0] mem_data_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
  localparam int CNT_W = OFF_W + 1;

  logic [OFF_W-1:0] lk_off;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             unused_byte_bits;

  assign lk_off = addr_i[2 +: OFF_W];
  assign lk_idx = addr_i[2+OFF_W +: IDX_W];
  assign lk_tag = addr_i[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^addr_i[1:0];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              inv_seen_q, inv_seen_d;

  logic [TAG_W-1:0]   rd_tag;
  logic [INSTR_W-1:0] rd_data;
  logic               rd_valid;
  logic               word_we, tag_we, valid_set, miss;

  icache_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (lk_idx),
    .rd_off_i    (lk_off),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .word_we_i   (word_we),
    .wr_idx_i    (idx_q),
    .wr_off_i    (cnt_q[OFF_W-1:0]),
    .wr_data_i   (mem_data_i),
    .tag_we_i    (tag_we),
    .tag_i       (base_q[ADDR_W-1 -: TAG_W]),
    .valid_set_i (valid_set),
    .inv_all_i   (inv_i)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    idx_d      = idx_q;
    inv_seen_d = inv_seen_q;
    hit_o      = 1'b0;
    data_o     = '0;
    stall_o    = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    word_we    = 1'b0;
    tag_we     = 1'b0;
    valid_set  = 1'b0;
    miss       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-cycle invalidate turns any lookup into a miss.
        hit_o   = req_i & rd_valid & (rd_tag == lk_tag) & ~inv_i;
        data_o  = hit_o ? rd_data : '0;
        miss    = req_i & ~hit_o;
        stall_o = miss;
        if (miss) begin
          state_d    = REFILL;
          base_d     = {lk_tag, lk_idx, {(OFF_W+2){1'b0}}};
          idx_d      = lk_idx;
          cnt_d      = '0;
          inv_seen_d = 1'b0;
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = base_q + ADDR_W'({cnt_q, 2'b00});
        inv_seen_d = inv_seen_q | inv_i;
        if (mem_ack_i) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS-1)) state_d = FINISH;
        end
      end
      FINISH: begin
        stall_o = 1'b1;
        tag_we  = 1'b1;
        // A line invalidated while it was being fetched must not become visible.
        valid_set = ~inv_seen_q & ~inv_i;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      inv_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      inv_seen_q <= inv_seen_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_o && (hit_cnt_q != 32'hFFFF_FFFF))  hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss && (miss_cnt_q != 32'hFFFF_FFFF))  miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
